// File: rtl/fma_driver.sv
// Sequences dot-product jobs onto an external registered FMA: seeds the accumulator
// with a bias on the first pair, streams pairs, then captures the FMA result.
module fma_driver #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [WIDTH-1:0]     bias_in,
    input  logic [WIDTH-1:0]     op_a_in,
    input  logic [WIDTH-1:0]     op_b_in,
    input  logic                 op_valid_in,
    input  logic                 op_last_in,
    output logic                 op_ready_out,
    output logic [WIDTH-1:0]     fma_a_out,
    output logic [WIDTH-1:0]     fma_b_out,
    output logic [WIDTH-1:0]     fma_c_out,
    output logic                 fma_a_valid_out,
    output logic                 fma_b_valid_out,
    output logic                 fma_c_valid_out,
    output logic                 fma_compute_out,
    input  logic [WIDTH-1:0]     fma_result_in,
    output logic [WIDTH-1:0]     result_out,
    output logic                 result_valid_out,
    input  logic                 result_ready_in,
    output logic [CNT_WIDTH-1:0] terms_out,
    output logic                 busy_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESULT} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     bias_q;
    logic [WIDTH-1:0]     result_q;
    logic [CNT_WIDTH-1:0] terms_q;
    logic                 first_q;
    logic                 hs;

    assign hs = op_valid_in & (state_q == ISSUE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_in)        state_d = ISSUE;
            ISSUE:   if (hs && op_last_in) state_d = DRAIN;
            DRAIN:                         state_d = RESULT;
            RESULT:  if (result_ready_in) state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // FMA buses are zero whenever no pair is handed over, so the FMA sees clean idle inputs
    always_comb begin
        op_ready_out     = (state_q == ISSUE);
        busy_out         = (state_q != IDLE);
        result_valid_out = (state_q == RESULT);
        fma_a_out        = '0;
        fma_b_out        = '0;
        fma_c_out        = '0;
        fma_a_valid_out  = 1'b0;
        fma_b_valid_out  = 1'b0;
        fma_c_valid_out  = 1'b0;
        fma_compute_out  = 1'b0;
        if (hs) begin
            fma_a_out       = op_a_in;
            fma_b_out       = op_b_in;
            fma_a_valid_out = 1'b1;
            fma_b_valid_out = 1'b1;
            fma_compute_out = 1'b1;
            if (first_q) begin
                fma_c_out       = bias_q;
                fma_c_valid_out = 1'b1;
            end
        end
    end

    // Job bookkeeping: bias/flag/counter at start, result capture in the drain cycle
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bias_q   <= '0;
            result_q <= '0;
            terms_q  <= '0;
            first_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && start_in) begin
                bias_q  <= bias_in;
                terms_q <= '0;
                first_q <= 1'b1;
            end
            if (hs) begin
                first_q <= 1'b0;
                if (terms_q != {CNT_WIDTH{1'b1}})
                    terms_q <= terms_q + CNT_WIDTH'(1);
            end
            if (state_q == DRAIN)
                result_q <= fma_result_in;
        end
    end

    assign result_out = result_q;
    assign terms_out  = terms_q;

endmodule

// File: tb/tb_fma_driver.sv
// Bench for fma_driver: two instances (wide and 2-bit term counter) share stimulus,
// each driving its own behavioural Q6.10 registered FMA; results checked against a dot-product reference.
module tb_fma_driver;

    localparam int W = 16;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          start_in = 1'b0;
    logic [W-1:0]  bias_in = '0;
    logic [W-1:0]  op_a_in = '0, op_b_in = '0;
    logic          op_valid_in = 1'b0, op_last_in = 1'b0;
    logic          result_ready_in = 1'b0;

    logic          op_ready_out, op_ready2;
    logic [W-1:0]  fma_a_out, fma_b_out, fma_c_out, fa2, fb2, fc2;
    logic          fma_a_valid_out, fma_b_valid_out, fma_c_valid_out, fma_compute_out;
    logic          fav2, fbv2, fcv2, fcomp2;
    logic [W-1:0]  fma_result_in, fres2, result_out, result2;
    logic          result_valid_out, rv2, busy_out, busy2;
    logic [7:0]    terms_out;
    logic [1:0]    terms2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    fma_driver #(.WIDTH(W), .CNT_WIDTH(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .bias_in(bias_in),
        .op_a_in(op_a_in), .op_b_in(op_b_in), .op_valid_in(op_valid_in), .op_last_in(op_last_in),
        .op_ready_out(op_ready_out), .fma_a_out(fma_a_out), .fma_b_out(fma_b_out), .fma_c_out(fma_c_out),
        .fma_a_valid_out(fma_a_valid_out), .fma_b_valid_out(fma_b_valid_out),
        .fma_c_valid_out(fma_c_valid_out), .fma_compute_out(fma_compute_out),
        .fma_result_in(fma_result_in), .result_out(result_out), .result_valid_out(result_valid_out),
        .result_ready_in(result_ready_in), .terms_out(terms_out), .busy_out(busy_out));

    fma_driver #(.WIDTH(W), .CNT_WIDTH(2)) dut2 (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .bias_in(bias_in),
        .op_a_in(op_a_in), .op_b_in(op_b_in), .op_valid_in(op_valid_in), .op_last_in(op_last_in),
        .op_ready_out(op_ready2), .fma_a_out(fa2), .fma_b_out(fb2), .fma_c_out(fc2),
        .fma_a_valid_out(fav2), .fma_b_valid_out(fbv2), .fma_c_valid_out(fcv2), .fma_compute_out(fcomp2),
        .fma_result_in(fres2), .result_out(result2), .result_valid_out(rv2),
        .result_ready_in(result_ready_in), .terms_out(terms2), .busy_out(busy2));

    // Fixed point with 10 fraction bits: product scaled back by 2^10
    function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [31:0] p;
        p = {16'h0, a} * {16'h0, b};
        return p[25:10];
    endfunction

    // Behavioural registered FMA accumulators
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) fma_result_in <= '0;
        else if (fma_compute_out)
            fma_result_in <= (fma_c_valid_out ? fma_c_out : fma_result_in) + fx_mul(fma_a_out, fma_b_out);
    end
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) fres2 <= '0;
        else if (fcomp2)
            fres2 <= (fcv2 ? fc2 : fres2) + fx_mul(fa2, fb2);
    end

    function automatic logic [W-1:0] ref_dot(input logic [W-1:0] bias, input int n,
                                             input logic [7:0][W-1:0] a, input logic [7:0][W-1:0] b);
        int unsigned s;
        s = bias;
        for (int i = 0; i < n; i++) s += ({16'h0, a[i]} * {16'h0, b[i]}) >> 10;
        return s[W-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0]        bias;
        int                  n;
        logic [7:0][W-1:0]   a;
        logic [7:0][W-1:0]   b;
        int                  gap;
        int                  hold;
        logic [W-1:0]        exp_res;
    } vec_t;

    vec_t vecs[5];

    task automatic run_job(input vec_t v, input string tag);
        int lat;
        int t2;
        t2 = (v.n > 3) ? 3 : v.n;
        @(negedge clk_in);
        start_in = 1'b1; bias_in = v.bias;
        @(negedge clk_in);
        start_in = 1'b0; bias_in = W'($urandom);
        chk({tag, ":busy"}, busy_out, 1);
        for (int i = 0; i < v.n; i++) begin
            for (int g = 0; g < v.gap && i > 0; g++) begin
                op_valid_in = 1'b0; op_a_in = W'($urandom); op_b_in = W'($urandom);
                #1;
                chk({tag, ":gap_strobes"},
                    {fma_a_valid_out, fma_b_valid_out, fma_c_valid_out, fma_compute_out, fma_a_out, fma_b_out}, 0);
                @(negedge clk_in);
            end
            op_valid_in = 1'b1; op_a_in = v.a[i]; op_b_in = v.b[i]; op_last_in = (i == v.n - 1);
            #1;
            chk({tag, ":hs_strobes"},
                {op_ready_out, fma_a_valid_out, fma_b_valid_out, fma_c_valid_out, fma_compute_out},
                {1'b1, 1'b1, 1'b1, (i == 0), 1'b1});
            chk({tag, ":hs_buses"}, {fma_a_out, fma_b_out}, {v.a[i], v.b[i]});
            chk({tag, ":c_bus"}, fma_c_out, (i == 0) ? v.bias : 16'h0);
            @(negedge clk_in);
        end
        op_valid_in = 1'b0; op_last_in = 1'b0;
        lat = 1;
        while (!result_valid_out && lat < 8) begin
            @(negedge clk_in);
            lat++;
        end
        chk({tag, ":latency"}, lat, 2);
        chk({tag, ":result"}, result_out, v.exp_res);
        chk({tag, ":terms"}, terms_out, v.n);
        chk({tag, ":result_sat"}, {rv2, result2}, {1'b1, v.exp_res});
        chk({tag, ":terms_sat"}, terms2, t2);
        for (int h = 0; h < v.hold; h++) begin
            start_in = (h == 1);
            @(negedge clk_in);
            start_in = 1'b0;
            chk({tag, ":hold"}, {result_valid_out, result_out}, {1'b1, v.exp_res});
        end
        result_ready_in = 1'b1;
        @(negedge clk_in);
        result_ready_in = 1'b0;
        chk({tag, ":idle"}, {busy_out, result_valid_out, op_ready_out}, 0);
        chk({tag, ":retain"}, {result_out, terms_out}, {v.exp_res, 8'(v.n)});
    endtask

    task automatic set_pair(input int k, input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        vecs[k].a[i] = a;
        vecs[k].b[i] = b;
    endtask

    initial begin
        vec_t rv;
        for (int k = 0; k < 5; k++) begin
            vecs[k].a = '0; vecs[k].b = '0; vecs[k].gap = 0; vecs[k].hold = 0;
        end
        vecs[0].bias = 16'h0400; vecs[0].n = 2; vecs[0].exp_res = 16'h1200;
        set_pair(0, 0, 16'h0800, 16'h0600); set_pair(0, 1, 16'h0200, 16'h0400);
        vecs[1].bias = 16'h0000; vecs[1].n = 1; vecs[1].exp_res = 16'h0400;
        set_pair(1, 0, 16'h0400, 16'h0400);
        vecs[2] = vecs[0]; vecs[2].gap = 3;
        vecs[3] = vecs[1]; vecs[3].hold = 5;
        vecs[4].bias = 16'h0000; vecs[4].n = 5; vecs[4].exp_res = 16'h1400;
        for (int i = 0; i < 5; i++) set_pair(4, i, 16'h0400, 16'h0400);

        // reset state
        #2;
        chk("reset_outputs", {op_ready_out, busy_out, result_valid_out, fma_compute_out, fma_c_valid_out}, 0);
        chk("reset_regs", {result_out, terms_out, terms2}, 0);
        @(negedge clk_in);
        rst_in = 1'b1;

        for (int k = 0; k < 5; k++) run_job(vecs[k], $sformatf("vec%0d", k));

        // reset in the middle of a job after one accepted pair
        @(negedge clk_in);
        start_in = 1'b1; bias_in = 16'h0400;
        @(negedge clk_in);
        start_in = 1'b0;
        op_valid_in = 1'b1; op_a_in = 16'h0400; op_b_in = 16'h0400;
        @(negedge clk_in);
        op_valid_in = 1'b0;
        #2 rst_in = 1'b0;
        #1;
        chk("midrst_now", {busy_out, op_ready_out, result_valid_out, terms_out, result_out}, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            chk("midrst_quiet", {busy_out, result_valid_out}, 0);
        end
        rst_in = 1'b1;
        run_job(vecs[0], "after_rst");

        // randomized jobs against the reference dot product
        for (int r = 0; r < 8; r++) begin
            rv.bias = W'($urandom);
            rv.n    = $urandom_range(1, 7);
            for (int i = 0; i < 8; i++) begin
                rv.a[i] = W'($urandom);
                rv.b[i] = W'($urandom);
            end
            rv.gap  = $urandom_range(0, 2);
            rv.hold = $urandom_range(0, 3);
            rv.exp_res = ref_dot(rv.bias, rv.n, rv.a, rv.b);
            run_job(rv, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
